// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM word-line controller.
package sram_ctrl_pkg;

  localparam int unsigned ADR_W = 4;
  localparam int unsigned NWL   = 16;

  // Requester indices into REQ / WE / ACK
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StAct,
    StAccess,
    StDone
  } state_e;

endpackage

// File: rtl/wl_onehot_dec.sv
// 4-to-16 one-hot word-line decoder; all lines low when disabled.
module wl_onehot_dec
  import sram_ctrl_pkg::*;
(
  input  logic [ADR_W-1:0] adr_i,
  input  logic             en_i,
  output logic [NWL-1:0]   wl_o
);

  always_comb begin
    wl_o = '0;
    if (en_i) begin
      wl_o[adr_i] = 1'b1;
    end
  end

endmodule

// File: rtl/sram_wl_ctrl.sv
// Two-requester SRAM access sequencer: precharge, word-line activate, sense/write, acknowledge.
// Define ARB_RR_EN for round-robin arbitration; otherwise fixed priority with A over B.
module sram_wl_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned DW         = 8,
  parameter int unsigned ACT_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       REQ,
  input  logic [1:0]       WE,
  input  logic [ADR_W-1:0] ADR_A,
  input  logic [ADR_W-1:0] ADR_B,
  input  logic [DW-1:0]    WDATA_A,
  input  logic [DW-1:0]    WDATA_B,
  output logic [1:0]       ACK,
  output logic [DW-1:0]    RDATA,
  output logic             BL_PRE,
  output logic [NWL-1:0]   WL,
  output logic             SAE,
  output logic             WDRV,
  output logic [DW-1:0]    WDATA_BL,
  input  logic [DW-1:0]    RDATA_BL,
  output logic             BUSY
);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic             we_q, we_d;
  logic [DW-1:0]    wdat_q, wdat_d;
  logic             win_q, win_d;
`ifdef ARB_RR_EN
  logic             last_q, last_d;
`endif

  logic [NWL-1:0]   wl_q, wl_d;
  logic             bl_pre_q, bl_pre_d;
  logic             sae_q, sae_d;
  logic             wdrv_q, wdrv_d;
  logic [DW-1:0]    wdata_bl_q, wdata_bl_d;
  logic [1:0]       ack_q, ack_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic             busy_q, busy_d;

  logic             gnt_idx;
  logic             wl_en;

  always_comb begin
`ifdef ARB_RR_EN
    if (REQ[REQ_A] && REQ[REQ_B]) begin
      gnt_idx = ~last_q;
    end else begin
      gnt_idx = REQ[REQ_A] ? REQ_A : REQ_B;
    end
`else
    gnt_idx = REQ[REQ_A] ? REQ_A : REQ_B;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    we_d    = we_q;
    wdat_d  = wdat_q;
    win_d   = win_q;
`ifdef ARB_RR_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (|REQ) begin
          state_d = StPre;
          win_d   = gnt_idx;
          adr_d   = (gnt_idx == REQ_B) ? ADR_B : ADR_A;
          we_d    = WE[gnt_idx];
          wdat_d  = (gnt_idx == REQ_B) ? WDATA_B : WDATA_A;
`ifdef ARB_RR_EN
          last_d  = gnt_idx;
`endif
        end
      end
      StPre: begin
        state_d = StAct;
        cnt_d   = 4'(ACT_CYCLES - 1);
      end
      StAct: begin
        if (cnt_q == 4'd0) begin
          state_d = StAccess;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StAccess: state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs are derived from the next state so they register in step with it
  always_comb begin
    bl_pre_d   = (state_d == StPre);
    wl_en      = (state_d == StAct) || (state_d == StAccess);
    sae_d      = (state_d == StAccess) && !we_d;
    wdrv_d     = (state_d == StAccess) && we_d;
    wdata_bl_d = wdrv_d ? wdat_d : '0;
    ack_d      = '0;
    if (state_d == StDone) begin
      ack_d[win_d] = 1'b1;
    end
    busy_d  = (state_d != StIdle);
    rdata_d = rdata_q;
    if ((state_q == StAccess) && !we_q) begin
      rdata_d = RDATA_BL;
    end
  end

  wl_onehot_dec u_wl_dec (
    .adr_i (adr_d),
    .en_i  (wl_en),
    .wl_o  (wl_d)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      adr_q      <= '0;
      we_q       <= 1'b0;
      wdat_q     <= '0;
      win_q      <= REQ_A;
`ifdef ARB_RR_EN
      last_q     <= REQ_B;
`endif
      wl_q       <= '0;
      bl_pre_q   <= 1'b0;
      sae_q      <= 1'b0;
      wdrv_q     <= 1'b0;
      wdata_bl_q <= '0;
      ack_q      <= '0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      adr_q      <= adr_d;
      we_q       <= we_d;
      wdat_q     <= wdat_d;
      win_q      <= win_d;
`ifdef ARB_RR_EN
      last_q     <= last_d;
`endif
      wl_q       <= wl_d;
      bl_pre_q   <= bl_pre_d;
      sae_q      <= sae_d;
      wdrv_q     <= wdrv_d;
      wdata_bl_q <= wdata_bl_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
    end
  end

  assign WL       = wl_q;
  assign BL_PRE   = bl_pre_q;
  assign SAE      = sae_q;
  assign WDRV     = wdrv_q;
  assign WDATA_BL = wdata_bl_q;
  assign ACK      = ack_q;
  assign RDATA    = rdata_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_sram_wl_ctrl.sv
// Self-checking bench for sram_wl_ctrl: directed scenarios plus randomized traffic
// compared against a cycles-since-grant transaction model.
module tb_sram_wl_ctrl;

  localparam int ACT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [1:0]  we = '0;
  logic [3:0]  adr_a = '0, adr_b = '0;
  logic [7:0]  wdata_a = '0, wdata_b = '0, rdata_bl = '0;
  logic [1:0]  ack;
  logic [7:0]  rdata, wdata_bl;
  logic        bl_pre, sae, wdrv, busy;
  logic [15:0] wl;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  sram_wl_ctrl #(.DW(8), .ACT_CYCLES(ACT)) dut (
    .CLK      (clk),
    .RST      (rst),
    .REQ      (req),
    .WE       (we),
    .ADR_A    (adr_a),
    .ADR_B    (adr_b),
    .WDATA_A  (wdata_a),
    .WDATA_B  (wdata_b),
    .ACK      (ack),
    .RDATA    (rdata),
    .BL_PRE   (bl_pre),
    .WL       (wl),
    .SAE      (sae),
    .WDRV     (wdrv),
    .WDATA_BL (wdata_bl),
    .RDATA_BL (rdata_bl),
    .BUSY     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  // Transaction model: m_age counts cycles since the grant edge.
  bit         m_busy = 1'b0;
  int         m_age = 0;
  logic [3:0] m_adr = '0;
  bit         m_we = 1'b0;
  logic [7:0] m_data = '0;
  int         m_win = 0;
  int         m_last = 1;
  logic [7:0] m_rdata = '0;
  int         m_acks = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy  = 1'b0;
      m_age   = 0;
      m_rdata = '0;
      m_last  = 1;
    end else if (!m_busy) begin
      if (req != 2'b00) begin
        if (req == 2'b11) begin
`ifdef ARB_RR_EN
          m_win = 1 - m_last;
`else
          m_win = 0;
`endif
        end else begin
          m_win = req[0] ? 0 : 1;
        end
        m_last = m_win;
        m_adr  = (m_win == 1) ? adr_b : adr_a;
        m_data = (m_win == 1) ? wdata_b : wdata_a;
        m_we   = we[m_win];
        m_busy = 1'b1;
        m_age  = 1;
      end
    end else begin
      if (m_age == ACT + 2 && !m_we) m_rdata = rdata_bl;
      if (m_age == ACT + 3) begin
        m_busy = 1'b0;
        m_age  = 0;
      end else begin
        m_age++;
        if (m_age == ACT + 3) m_acks++;
      end
    end
  end

  logic [15:0] e_wl;
  logic [7:0]  e_wdbl;
  logic [1:0]  e_ack;
  logic        e_bl, e_acc, e_sae, e_wdrv;

  always @(negedge clk) begin
    if (mon_en) begin
      e_bl   = m_busy && m_age == 1;
      e_wl   = (m_busy && m_age >= 2 && m_age <= ACT + 2) ? (16'h1 << m_adr) : 16'h0;
      e_acc  = m_busy && m_age == ACT + 2;
      e_sae  = e_acc && !m_we;
      e_wdrv = e_acc && m_we;
      e_wdbl = e_wdrv ? m_data : 8'h00;
      e_ack  = (m_busy && m_age == ACT + 3) ? (2'b01 << m_win) : 2'b00;
      checks++;
      if (wl !== e_wl) begin
        errors++; $display("FAIL mon_wl t=%0t got=%h exp=%h", $time, wl, e_wl);
      end
      checks++;
      if (bl_pre !== e_bl) begin
        errors++; $display("FAIL mon_bl_pre t=%0t got=%b exp=%b", $time, bl_pre, e_bl);
      end
      checks++;
      if (sae !== e_sae) begin
        errors++; $display("FAIL mon_sae t=%0t got=%b exp=%b", $time, sae, e_sae);
      end
      checks++;
      if (wdrv !== e_wdrv) begin
        errors++; $display("FAIL mon_wdrv t=%0t got=%b exp=%b", $time, wdrv, e_wdrv);
      end
      checks++;
      if (wdata_bl !== e_wdbl) begin
        errors++; $display("FAIL mon_wdata_bl t=%0t got=%h exp=%h", $time, wdata_bl, e_wdbl);
      end
      checks++;
      if (ack !== e_ack) begin
        errors++; $display("FAIL mon_ack t=%0t got=%b exp=%b", $time, ack, e_ack);
      end
      checks++;
      if (busy !== m_busy) begin
        errors++; $display("FAIL mon_busy t=%0t got=%b exp=%b", $time, busy, m_busy);
      end
      checks++;
      if (rdata !== m_rdata) begin
        errors++; $display("FAIL mon_rdata t=%0t got=%h exp=%h", $time, rdata, m_rdata);
      end
      checks++;
      if (!$onehot0(wl)) begin
        errors++; $display("FAIL prop_wl_onehot0 t=%0t got=%h exp=onehot0", $time, wl);
      end
      checks++;
      if ((|wl) && bl_pre) begin
        errors++; $display("FAIL prop_wl_bl_pre t=%0t got wl=%h bl_pre=1 exp wl=0", $time, wl);
      end
      checks++;
      if (sae && wdrv) begin
        errors++; $display("FAIL prop_sae_wdrv t=%0t got both=1 exp not both", $time);
      end
      checks++;
      if (!$onehot0(ack)) begin
        errors++; $display("FAIL prop_ack_onehot0 t=%0t got=%b exp=onehot0", $time, ack);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 2'($urandom);
    tick();
    mon_en = 1'b1;
    tick();
    checks++;
    if ({wl, bl_pre, sae, wdrv, ack, busy, wdata_bl} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got wl=%h pre=%b sae=%b wdrv=%b ack=%b busy=%b wdbl=%h exp all 0",
               wl, bl_pre, sae, wdrv, ack, busy, wdata_bl);
    end
    checks++;
    if (rdata !== 8'h00) begin
      errors++; $display("FAIL reset_rdata got=%h exp=00", rdata);
    end
    rst = 1'b0;
    req = 2'b00;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL idle_no_req_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_read_a5();
    int pre_n, wl_n, sae_idx, ack_at;
    pre_n = 0; wl_n = 0; sae_idx = -1; ack_at = -1;
    adr_a = 4'h5; we = 2'b00; rdata_bl = 8'h3C; req = 2'b01;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (bl_pre) pre_n++;
      if (wl == 16'h0020) wl_n++;
      if (sae) sae_idx = wl_n;
      if (ack[0]) begin
        ack_at = c;
        req = 2'b00;
        break;
      end
    end
    checks++;
    if (pre_n != 1) begin
      errors++; $display("FAIL read_bl_pre_cycles got=%0d exp=1", pre_n);
    end
    checks++;
    if (wl_n != ACT + 1) begin
      errors++; $display("FAIL read_wl_cycles got=%0d exp=%0d", wl_n, ACT + 1);
    end
    checks++;
    if (sae_idx != ACT + 1) begin
      errors++; $display("FAIL read_sae_position got=%0d exp=%0d", sae_idx, ACT + 1);
    end
    checks++;
    if (ack_at != ACT + 3) begin
      errors++; $display("FAIL read_ack_latency got=%0d exp=%0d", ack_at, ACT + 3);
    end
    checks++;
    if (rdata !== 8'h3C) begin
      errors++; $display("FAIL read_rdata got=%h exp=3c", rdata);
    end
    tick();
  endtask

  task automatic test_write_bf();
    int wl_n, wl_bad, wdrv_ok, sae_n, ack_at;
    logic [1:0] ack_seen;
    wl_n = 0; wl_bad = 0; wdrv_ok = 0; sae_n = 0; ack_at = -1; ack_seen = '0;
    adr_a = 4'h3; wdata_a = 8'h11; adr_b = 4'hF; wdata_b = 8'hA5; we = 2'b10;
    rdata_bl = 8'hEE; req = 2'b10;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (wl == 16'h8000) wl_n++;
      else if (wl != 16'h0) wl_bad++;
      if (wdrv && wdata_bl == 8'hA5) wdrv_ok++;
      if (sae) sae_n++;
      if (ack != 2'b00) begin
        ack_at = c;
        ack_seen = ack;
        req = 2'b00;
        break;
      end
    end
    checks++;
    if (wl_n != ACT + 1 || wl_bad != 0) begin
      errors++; $display("FAIL write_wl got=%0d good/%0d bad exp=%0d/0", wl_n, wl_bad, ACT + 1);
    end
    checks++;
    if (wdrv_ok != 1 || sae_n != 0) begin
      errors++; $display("FAIL write_drive got wdrv_ok=%0d sae=%0d exp 1/0", wdrv_ok, sae_n);
    end
    checks++;
    if (ack_seen !== 2'b10 || ack_at != ACT + 3) begin
      errors++; $display("FAIL write_ack got=%b@%0d exp=10@%0d", ack_seen, ack_at, ACT + 3);
    end
    checks++;
    if (rdata !== 8'h3C) begin
      errors++; $display("FAIL write_rdata_held got=%h exp=3c", rdata);
    end
    tick();
  endtask

  task automatic test_arb();
    int got[$];
    int exp_w[4];
`ifdef ARB_RR_EN
    exp_w = '{0, 1, 0, 1};
`else
    exp_w = '{0, 0, 0, 0};
`endif
    we = 2'b00; rdata_bl = 8'h77; adr_a = 4'h2; adr_b = 4'hC; req = 2'b11;
    for (int c = 0; c < 60 && got.size() < 4; c++) begin
      tick();
      if (ack == 2'b01) got.push_back(0);
      if (ack == 2'b10) got.push_back(1);
    end
    req = 2'b00;
    checks++;
    if (got.size() != 4) begin
      errors++; $display("FAIL arb_ack_count got=%0d exp=4", got.size());
    end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++;
      if (got[i] != exp_w[i]) begin
        errors++; $display("FAIL arb_order[%0d] got=%0d exp=%0d", i, got[i], exp_w[i]);
      end
    end
    checks++;
    if (rdata !== 8'h77) begin
      errors++; $display("FAIL arb_rdata got=%h exp=77", rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int ack_n, ack_at;
    ack_n = 0; ack_at = -1;
    adr_a = 4'($urandom); we = 2'b00; rdata_bl = 8'hFF; req = 2'b01;
    tick();
    tick();
    checks++;
    if (wl == 16'h0) begin
      errors++; $display("FAIL rstmid_in_act got wl=%h exp nonzero", wl);
    end
    rst = 1'b1; req = 2'b00;
    tick();
    rst = 1'b0;
    checks++;
    if (wl !== 16'h0 || busy !== 1'b0 || ack !== 2'b00) begin
      errors++; $display("FAIL rstmid_abort got wl=%h busy=%b ack=%b exp 0/0/0", wl, busy, ack);
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      if (ack != 2'b00) ack_n++;
    end
    checks++;
    if (ack_n != 0 || rdata !== 8'h00) begin
      errors++; $display("FAIL rstmid_no_ack got acks=%0d rdata=%h exp 0/00", ack_n, rdata);
    end
    adr_a = 4'h7; rdata_bl = 8'h5A; req = 2'b01;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (ack[0]) begin
        ack_at = c;
        req = 2'b00;
        break;
      end
    end
    checks++;
    if (ack_at != ACT + 3 || rdata !== 8'h5A) begin
      errors++; $display("FAIL rstmid_fresh got lat=%0d rdata=%h exp %0d/5a", ack_at, rdata, ACT + 3);
    end
    tick();
  endtask

  task automatic test_adr_change();
    int wl_n, wl_bad, ack_at;
    wl_n = 0; wl_bad = 0; ack_at = -1;
    adr_a = 4'h1; we = 2'b00; req = 2'b01;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 1) begin
        adr_a = 4'h9; we = 2'($urandom); wdata_a = 8'($urandom);
      end
      if (wl == 16'h0002) wl_n++;
      else if (wl != 16'h0) wl_bad++;
      if (ack[0]) begin
        ack_at = c;
        req = 2'b00;
        break;
      end
    end
    checks++;
    if (wl_n != ACT + 1 || wl_bad != 0) begin
      errors++; $display("FAIL adr_change_wl got=%0d good/%0d bad exp=%0d/0", wl_n, wl_bad, ACT + 1);
    end
    checks++;
    if (ack_at != ACT + 3) begin
      errors++; $display("FAIL adr_change_latency got=%0d exp=%0d", ack_at, ACT + 3);
    end
    tick();
  endtask

  task automatic test_random();
    int m0, dut_acks;
    m0 = m_acks; dut_acks = 0;
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < 2; i++) begin
        if (ack[i]) begin
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
        end
      end
      we = 2'($urandom);
      adr_a = 4'($urandom); adr_b = 4'($urandom);
      wdata_a = 8'($urandom); wdata_b = 8'($urandom); rdata_bl = 8'($urandom);
      tick();
      dut_acks += int'(ack[0]) + int'(ack[1]);
    end
    rst = 1'b0;
    checks++;
    if (dut_acks != m_acks - m0) begin
      errors++; $display("FAIL random_ack_total got=%0d exp=%0d", dut_acks, m_acks - m0);
    end
    req = 2'b00;
    for (int c = 0; c < ACT + 6; c++) tick();
  endtask

  initial begin
    test_reset();
    test_read_a5();
    test_write_bf();
    test_arb();
    test_reset_mid();
    test_adr_change();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
